complex_op_sequencer: RTL
=========================

// Module: complex_op_sequencer
// PURPOSE
//  Multi-cycle controller that runs complex add/multiply on one shared signed multiplier.
//  Uses the 3-multiplier identity: re = ac - bd, im = (a+b)(c+d) - ac - bd.
//  Sits between an upstream operand source (valid/ready) and a downstream result sink (valid/ready).
//  Trades throughput for area: one multiply per cycle, one operation in flight.
// PARAMETERS
//  W   16  operand/result width, signed two's complement
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operand set + op presented
//  in_ready   out  1    sequencer can accept (state IDLE)
//  in_op      in   1    0 = ADD, 1 = MUL
//  in_a       in   W    real part of operand 1
//  in_b       in   W    imaginary part of operand 1
//  in_c       in   W    real part of operand 2
//  in_d       in   W    imaginary part of operand 2
//  out_valid  out  1    result held, state DONE
//  out_ready  in   1    sink accepts result
//  out_re     out  W    real result, low W bits
//  out_im     out  W    imaginary result, low W bits
//  out_op     out  1    op that produced the result
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  Clock and reset:
//  - One clock, clk. Reset rst_n is asynchronous assert, active-low; release is synchronised externally.
//  - Reset (any state, incl. mid-multiply): state=IDLE; out_valid=0, out_re=0, out_im=0, out_op=0.
//  - Reset also clears operand regs and accumulators ac, bd. In-flight op is dropped, no result.
//  States: IDLE, MUL_AC, MUL_BD, MUL_S, DONE.
//  - in_ready = (state==IDLE); out_valid = (state==DONE).
//  - in_valid is ignored in all other states; no overlap.
//  Accept = in_valid & in_ready at edge k.
//  - Capture a, b, c, d, op.
//  - ADD: out_re=a+c, out_im=b+d registered at edge k; -> DONE. out_valid high from cycle k+1.
//  - MUL: -> MUL_AC.
//  MUL_AC: mult(a,c) -> ac; -> MUL_BD.
//  MUL_BD: mult(b,d) -> bd; -> MUL_S.
//  MUL_S:  mult(a+b, c+d) -> s; register out_re=ac-bd, out_im=s-ac-bd; -> DONE.
//  - MUL out_valid rises 4 cycles after the accept edge.
//  DONE:
//  - Hold out_re, out_im, out_op stable while out_ready=0, indefinitely.
//  - out_valid & out_ready -> IDLE. Next accept is possible one cycle later.
//  - Minimum issue interval: ADD 2 cycles, MUL 5 cycles.
//  Arithmetic:
//  - Pre-sums a+b and c+d are W+1 bits, sign-extended.
//  - Multiplier is (W+1)x(W+1) -> 2W+2 bits signed. ac and bd are kept at 2W+2 bits.
//  - Subtractions are done at 2W+2 bits, then truncated to the low W bits (wrap, no saturation).
//  - ADD is W-bit wrap. No overflow flag.
//  - The multiplier operand mux is driven only from state; no X propagates in IDLE/DONE (operands forced 0).
//  Simultaneous events:
//  - in_valid while DONE and out_ready=1: not accepted this cycle; in_ready is only high in IDLE.
// STRUCTURE
//  Package complex_alu_pkg:
//  - typedef op_t {OP_ADD=1'b0, OP_MUL=1'b1}.
//  - typedef state_t {IDLE, MUL_AC, MUL_BD, MUL_S, DONE}, 3-bit encoding.
//  - localparam MUL_LAT=4, ADD_LAT=1.
//  Sub-module cmul_shared_mult:
//  - Combinational signed (W+1)x(W+1) multiplier, so it can later be pipelined or swapped for a DSP.
//  Top level holds the FSM, operand regs, ac/bd regs, operand mux and output regs.
// TESTING
//  1. MUL a=3,b=4,c=5,d=6 -> re=-9, im=38; out_valid exactly 4 cycles after accept.
//  2. ADD a=3,b=4,c=5,d=6 -> re=8, im=10 one cycle after accept; out_op=0.
//  3. MUL a=32767,b=0,c=2,d=0 -> re=16'hFFFE (-2), im=0 (wrap).
//     MUL a=-32768,b=-32768,c=-1,d=-1 -> re=0, im=0 (pre-sums need 17 bits).
//  4. Backpressure: out_ready=0 for 6 cycles in DONE -> outputs stable, in_ready=0.
//     A second in_valid held high is accepted 1 cycle after the out handshake.
//  5. Reset asserted in MUL_BD -> outputs 0, IDLE immediately (async).
//     A fresh MUL after release gives a correct result with no stale ac.
//  6. Back-to-back stream of 20 random ADD/MUL with random out_ready.
//     Compare against a reference model; check ordering and that none are dropped or duplicated.

Source files
------------

// File: rtl/complex_alu_pkg.sv
// -----------------------------------------------------------------------------
// complex_alu_pkg
// Shared types and constants for the complex add/multiply sequencer.
//   op_t    : operation selector (ADD / MUL)
//   state_t : sequencer FSM state, 3-bit encoding
//   MUL_LAT : cycles from accept to out_valid for a multiply (accept cycle = 1)
//   ADD_LAT : cycles from accept to out_valid for an add (accept cycle = 1)
// -----------------------------------------------------------------------------
package complex_alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_AC = 3'd1,
    MUL_BD = 3'd2,
    MUL_S  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int MUL_LAT = 4;
  localparam int ADD_LAT = 1;

endpackage : complex_alu_pkg

// File: rtl/cmul_shared_mult.sv
// -----------------------------------------------------------------------------
// cmul_shared_mult
// Combinational signed (W+1)x(W+1) -> (2W+2) multiplier shared by all three
// partial products of the complex multiply. Kept as its own module so it can
// be pipelined or mapped onto a DSP block without touching the sequencer.
// Ports:
//   op_x  in  W+1   signed multiplicand
//   op_y  in  W+1   signed multiplier
//   prod  out 2W+2  signed product (exact, cannot overflow)
// -----------------------------------------------------------------------------
module cmul_shared_mult #(
  parameter int W = 16
) (
  input  logic signed [W:0]     op_x,
  input  logic signed [W:0]     op_y,
  output logic signed [2*W+1:0] prod
);

  // Both operands are signed, so they are sign-extended to the 2W+2 result
  // width before multiplying.
  assign prod = op_x * op_y;

endmodule : cmul_shared_mult

// File: rtl/complex_op_sequencer.sv
// -----------------------------------------------------------------------------
// complex_op_sequencer
// Multi-cycle complex ADD / MUL unit with one shared signed multiplier.
// MUL uses the 3-multiply form:
//   re = ac - bd
//   im = (a+b)(c+d) - ac - bd
// Only one operation is in flight at a time.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   in_op               0 = ADD, 1 = MUL
//   in_a,in_b           operand 1 (re, im), signed W bits
//   in_c,in_d           operand 2 (re, im), signed W bits
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   out_re,out_im       result, low W bits (wraps)
//   out_op              op that produced the result
//   busy                state != IDLE
// -----------------------------------------------------------------------------
module complex_op_sequencer
  import complex_alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         out_op,
  output logic         busy
);

  localparam int PW = 2 * W + 2;

  state_t state_q, state_d;

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] c_q, c_d;
  logic [W-1:0] d_q, d_d;
  op_t          op_q, op_d;

  logic signed [PW-1:0] ac_q, ac_d;
  logic signed [PW-1:0] bd_q, bd_d;

  logic [W-1:0] out_re_q, out_re_d;
  logic [W-1:0] out_im_q, out_im_d;
  op_t          out_op_q, out_op_d;

  // Multiplier datapath
  logic signed [W:0]    sum_ab;
  logic signed [W:0]    sum_cd;
  logic signed [W:0]    mul_x;
  logic signed [W:0]    mul_y;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] re_full;
  logic signed [PW-1:0] im_full;
  logic                 unused_hi_bits;

  // Pre-sums carry one extra bit so e.g. -32768 + -32768 is exact.
  assign sum_ab = {a_q[W-1], a_q} + {b_q[W-1], b_q};
  assign sum_cd = {c_q[W-1], c_q} + {d_q[W-1], d_q};

  // Operand mux depends on state alone; outside the multiply states both
  // inputs are zero so nothing undefined reaches the multiplier.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      MUL_AC: begin
        mul_x = {a_q[W-1], a_q};
        mul_y = {c_q[W-1], c_q};
      end
      MUL_BD: begin
        mul_x = {b_q[W-1], b_q};
        mul_y = {d_q[W-1], d_q};
      end
      MUL_S: begin
        mul_x = sum_ab;
        mul_y = sum_cd;
      end
      default: begin
        mul_x = '0;
        mul_y = '0;
      end
    endcase
  end

  cmul_shared_mult #(
    .W (W)
  ) u_mult (
    .op_x (mul_x),
    .op_y (mul_y),
    .prod (prod)
  );

  // Full-width differences; only the low W bits are kept (wrap semantics).
  // In MUL_S the multiplier output is (a+b)(c+d).
  assign re_full = ac_q - bd_q;
  assign im_full = prod - ac_q - bd_q;

  // High bits are intentionally discarded by the wrap-around truncation.
  assign unused_hi_bits = ^{re_full[PW-1:W], im_full[PW-1:W]};

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    op_d     = op_q;
    ac_d     = ac_q;
    bd_d     = bd_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    out_op_d = out_op_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d  = in_a;
          b_d  = in_b;
          c_d  = in_c;
          d_d  = in_d;
          op_d = op_t'(in_op);
          if (op_t'(in_op) == OP_MUL) begin
            state_d = MUL_AC;
          end else begin
            // ADD completes in the accept cycle itself.
            out_re_d = in_a + in_c;
            out_im_d = in_b + in_d;
            out_op_d = OP_ADD;
            state_d  = DONE;
          end
        end
      end
      MUL_AC: begin
        ac_d    = prod;
        state_d = MUL_BD;
      end
      MUL_BD: begin
        bd_d    = prod;
        state_d = MUL_S;
      end
      MUL_S: begin
        out_re_d = re_full[W-1:0];
        out_im_d = im_full[W-1:0];
        out_op_d = op_q;
        state_d  = DONE;
      end
      DONE: begin
        // Result registers simply hold until the sink takes them.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      op_q     <= OP_ADD;
      ac_q     <= '0;
      bd_q     <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
      out_op_q <= OP_ADD;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      op_q     <= op_d;
      ac_q     <= ac_d;
      bd_q     <= bd_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      out_op_q <= out_op_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_op    = out_op_q;

endmodule : complex_op_sequencer
